// File: rtl/filter.sv
// First-order IIR stage on sign-magnitude Q-format samples:
// y[n] = b0*x[n] + b1*x[n-1] - a1*y[n-1], combinational output, registered history.
module filter #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] y
);

  localparam int MW = WIDTH - 1;
  localparam int PW = 2 * MW;
  // Three truncated products plus sign and carry headroom never overflow this width.
  localparam int SW = PW - FRAC + 3;

  localparam logic [SW-1:0] MAG_MAX = SW'({MW{1'b1}});

  logic [WIDTH-1:0]     xd;
  logic [WIDTH-1:0]     yd;
  logic signed [SW-1:0] p0;
  logic signed [SW-1:0] p1;
  logic signed [SW-1:0] p2;
  logic signed [SW-1:0] sum;
  logic [SW-1:0]        abs_sum;
  logic [MW-1:0]        mag;
  logic                 neg;

  // Magnitude product truncated toward zero, then signed; a zero magnitude
  // (including negative zero) yields zero regardless of sign bits.
  function automatic logic signed [SW-1:0] sm_mul(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [PW-1:0] prod;
    logic [SW-1:0] pmag;
    prod = PW'(a[MW-1:0]) * PW'(b[MW-1:0]);
    pmag = SW'(prod >> FRAC);
    if (a[WIDTH-1] ^ b[WIDTH-1])
      return -$signed(pmag);
    else
      return $signed(pmag);
  endfunction

  always_comb begin
    p0      = sm_mul(b0, x);
    p1      = sm_mul(b1, xd);
    p2      = sm_mul(a1, yd);
    sum     = p0 + p1 - p2;
    neg     = sum[SW-1];
    abs_sum = neg ? SW'(-sum) : SW'(sum);
    mag     = '0;
    if (abs_sum > MAG_MAX)
      mag = MAG_MAX[MW-1:0];
    else
      mag = abs_sum[MW-1:0];
    // Sign only set for a nonzero magnitude so 0x8000 is never emitted.
    y = {neg && (mag != '0), mag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xd <= '0;
      yd <= '0;
    end else begin
      xd <= x;
      yd <= y;
    end
  end

endmodule

// File: tb/tb_filter.sv
// Directed self-checking bench for the filter stage; expected values are
// hand-computed from the Q8.8 sign-magnitude difference equation.
module tb_filter;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic [15:0] a1;
  logic [15:0] b0;
  logic [15:0] b1;
  logic [15:0] y;

  int test_count = 0;
  int fail_count = 0;

  filter #(.WIDTH(16), .FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .a1  (a1),
    .b0  (b0),
    .b1  (b1),
    .y   (y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] a1v,
                               input logic [15:0] b0v, input logic [15:0] b1v);
    x  = xv;
    a1 = a1v;
    b0 = b0v;
    b1 = b1v;
    #1;
  endtask

  // Leaves 8 time units of quiet before the next rising edge.
  task automatic stepClock();
    @(posedge clk);
    #2;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(16'h0080, 16'h80D2, 16'h0016, 16'h0016);
    checkOutput("reset_y", y, 16'h000B);
    applyStimulus(16'h0000, 16'h80D2, 16'h0016, 16'h0016);
    checkOutput("reset_zero", y, 16'h0000);
    applyStimulus(16'h0080, 16'h80D2, 16'h0016, 16'h0016);
    rst = 1'b0;
    #1;
    checkOutput("first_sample", y, 16'h000B);

    stepClock();
    applyStimulus(16'h00B3, 16'h80D2, 16'h0016, 16'h0016);
    checkOutput("second_sample", y, 16'h0023);

    stepClock();
    pulseReset();
    applyStimulus(16'h8080, 16'h80D2, 16'h0016, 16'h0016);
    checkOutput("neg_input", y, 16'h800B);
    applyStimulus(16'h8000, 16'h80D2, 16'h0016, 16'h0016);
    checkOutput("neg_zero", y, 16'h0000);

    stepClock();
    pulseReset();
    applyStimulus(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
    checkOutput("sat_pos", y, 16'h7FFF);
    applyStimulus(16'h7FFF, 16'h0000, 16'hFFFF, 16'h0000);
    checkOutput("sat_neg", y, 16'hFFFF);

    stepClock();
    pulseReset();
    applyStimulus(16'h0080, 16'h80D2, 16'h0016, 16'h0016);
    stepClock();
    applyStimulus(16'h00B3, 16'h80D2, 16'h0016, 16'h0016);
    checkOutput("stream_s1", y, 16'h0023);
    stepClock();
    applyStimulus(16'h0100, 16'h80D2, 16'h0016, 16'h0016);
    checkOutput("stream_s2", y, 16'h0041);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_held", y, 16'h0016);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_released", y, 16'h0016);
    stepClock();
    applyStimulus(16'h0000, 16'h80D2, 16'h0016, 16'h0016);
    checkOutput("after_rst_sample", y, 16'h0028);

    stepClock();
    pulseReset();
    applyStimulus(16'h0100, 16'h8080, 16'h0100, 16'h0000);
    checkOutput("impulse_0", y, 16'h0100);
    for (int k = 1; k <= 4; k++) begin
      stepClock();
      applyStimulus(16'h0000, 16'h8080, 16'h0100, 16'h0000);
      checkOutput($sformatf("impulse_%0d", k), y, 16'(16'h0100 >> k));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
